// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, reset PC default, opcodes,
// instruction field positions and the branch offset helper.
package cpu_pkg;

    typedef enum logic [0:0] {
        StFetch,
        StHold
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 26;
    localparam int unsigned FUNCT_MSB  = 5;
    localparam int unsigned FUNCT_LSB  = 0;

    // Word-aligned, sign-extended byte offset of a branch immediate.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: downstream control, instruction-memory bus and the
// presented instruction. master = fetch unit side, slave = environment side.
interface fetch_unit_if;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_pc;
    logic [15:0] branch_imm;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [5:0]  opCode;
    logic [5:0]  funct;

    modport master (
        input  stall, branch_taken, branch_pc, branch_imm, imem_ready, imem_rdata,
        output imem_req, imem_addr, if_valid, if_instr, if_pc, opCode, funct
    );

    modport slave (
        output stall, branch_taken, branch_pc, branch_imm, imem_ready, imem_rdata,
        input  imem_req, imem_addr, if_valid, if_instr, if_pc, opCode, funct
    );
endinterface

// File: rtl/branch_target_calc.sv
// Combinational taken-branch target: branch_pc + 4 + (sext(imm) << 2), mod 2^32.
module branch_target_calc
    import cpu_pkg::*;
(
    input  logic [31:0] branch_pc,
    input  logic [15:0] branch_imm,
    output logic [31:0] target
);
    assign target = branch_pc + 32'd4 + branch_offset(branch_imm);
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: FETCH/HOLD FSM with branch redirect and squash of
// in-flight words. Define FETCH_PERF_CNT_EN to add fetch/squash counters.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    fetch_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] squash_cnt
`endif
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  req_addr_q, req_addr_d;
    logic         squash_q, squash_d;
    logic         if_valid_q, if_valid_d;
    logic [31:0]  if_instr_q, if_instr_d;
    logic [31:0]  if_pc_q, if_pc_d;
    logic [31:0]  target;
    logic         capture;
    logic         discard;

    branch_target_calc u_target (
        .branch_pc  (bus.branch_pc),
        .branch_imm (bus.branch_imm),
        .target     (target)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        squash_d   = squash_q;
        if_valid_d = if_valid_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        capture    = 1'b0;
        discard    = 1'b0;
        case (state_q)
            StFetch: begin
                if (bus.imem_ready) begin
                    if (bus.branch_taken) begin
                        discard    = 1'b1;
                        pc_d       = target;
                        req_addr_d = target;
                        squash_d   = 1'b0;
                    end else if (squash_q) begin
                        discard    = 1'b1;
                        squash_d   = 1'b0;
                        req_addr_d = pc_q;
                    end else begin
                        capture    = 1'b1;
                        if_instr_d = bus.imem_rdata;
                        if_pc_d    = req_addr_q;
                        if_valid_d = 1'b1;
                        pc_d       = req_addr_q + 32'd4;
                        state_d    = StHold;
                    end
                end else if (bus.branch_taken) begin
                    // Request address must stay stable; redirect once it completes.
                    pc_d     = target;
                    squash_d = 1'b1;
                end
            end
            StHold: begin
                if (bus.branch_taken) begin
                    if_valid_d = 1'b0;
                    pc_d       = target;
                    req_addr_d = target;
                    state_d    = StFetch;
                end else if (!bus.stall) begin
                    if_valid_d = 1'b0;
                    req_addr_d = pc_q;
                    state_d    = StFetch;
                end
            end
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StFetch;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            squash_q   <= 1'b0;
            if_valid_q <= 1'b0;
            if_instr_q <= 32'h0;
            if_pc_q    <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            squash_q   <= squash_d;
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
        end
    end

    assign bus.imem_req  = (state_q == StFetch) && !rst;
    assign bus.imem_addr = req_addr_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.if_instr  = if_instr_q;
    assign bus.if_pc     = if_pc_q;
    // Invalid slots decode as a no-write R-type.
    assign bus.opCode    = if_valid_q ? if_instr_q[OPCODE_MSB:OPCODE_LSB] : OP_RTYPE;
    assign bus.funct     = if_valid_q ? if_instr_q[FUNCT_MSB:FUNCT_LSB] : 6'h0;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, squash_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q  <= 32'h0;
            squash_cnt_q <= 32'h0;
        end else begin
            if (capture && fetch_cnt_q != 32'hFFFF_FFFF) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (discard && squash_cnt_q != 32'hFFFF_FFFF) begin
                squash_cnt_q <= squash_cnt_q + 32'd1;
            end
        end
    end

    assign fetch_cnt  = fetch_cnt_q;
    assign squash_cnt = squash_cnt_q;
`else
    logic unused_cnt;
    assign unused_cnt = capture ^ discard;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed vectors, queued expectations,
// negedge monitor for accepted requests and presented instructions.
module tb_fetch_unit;
    import cpu_pkg::*;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [5:0]  op;
        logic [5:0]  fn;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst1 = 1'b1;
    int   total = 0;
    int   bad = 0;
    logic held = 1'b0;

    logic [31:0] exp_req[$];
    exp_t        exp_ins[$];

    fetch_unit_if ifc ();
    fetch_unit_if ifc1 ();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt, squash_cnt, fetch_cnt1, squash_cnt1;
`endif

    fetch_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt  (fetch_cnt),
        .squash_cnt (squash_cnt)
`endif
    );

    fetch_unit #(.RESET_PC(32'h0000_0100)) dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (ifc1)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt  (fetch_cnt1),
        .squash_cnt (squash_cnt1)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memword(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h2008_0005;
            32'h0000_0004: return 32'h0109_5020;
            32'h0000_0010: return 32'hAC43_0008;
            32'hFFFF_FFFC: return 32'h1022_0003;
            default:       return 32'hDEAD_BEEF;
        endcase
    endfunction

    always_comb ifc.imem_rdata = memword(ifc.imem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: accepted requests and newly presented instructions.
    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else begin
            if (ifc.imem_req && ifc.imem_ready) begin
                if (exp_req.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL req_unexpected: got addr %h expected none", ifc.imem_addr);
                end else begin
                    check("req_addr", ifc.imem_addr, exp_req.pop_front());
                end
            end
            if (ifc.if_valid && !held) begin
                if (exp_ins.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL instr_unexpected: got pc %h expected none", ifc.if_pc);
                end else begin
                    exp_t e;
                    e = exp_ins.pop_front();
                    check("if_instr", ifc.if_instr, e.instr);
                    check("if_pc", ifc.if_pc, e.pc);
                    check("opCode", {26'h0, ifc.opCode}, {26'h0, e.op});
                    check("funct", {26'h0, ifc.funct}, {26'h0, e.fn});
                end
            end
            held = ifc.if_valid && ifc.stall && !ifc.branch_taken;
        end
    end

    initial begin
        ifc.stall = 1'b0;
        ifc.branch_taken = 1'b0;
        ifc.branch_pc = 32'h0;
        ifc.branch_imm = 16'h0;
        ifc.imem_ready = 1'b1;
        ifc1.stall = 1'b0;
        ifc1.branch_taken = 1'b0;
        ifc1.branch_pc = 32'h0;
        ifc1.branch_imm = 16'h0;
        ifc1.imem_ready = 1'b0;
        ifc1.imem_rdata = 32'h0;

        // Reset state
        step(2);
        check("rst_imem_req", {31'h0, ifc.imem_req}, 32'h0);
        check("rst_imem_addr", ifc.imem_addr, 32'h0);
        check("rst_if_valid", {31'h0, ifc.if_valid}, 32'h0);
        check("rst_if_instr", ifc.if_instr, 32'h0);
        check("rst_if_pc", ifc.if_pc, 32'h0);
        check("rst_opcode", {26'h0, ifc.opCode}, 32'h0);

        // Straight-line fetch with ready tied high
        exp_req.push_back(32'h0);
        exp_req.push_back(32'h4);
        exp_ins.push_back('{32'h2008_0005, 32'h0, OP_ADDI, 6'h05});
        exp_ins.push_back('{32'h0109_5020, 32'h4, OP_RTYPE, 6'h20});
        rst = 1'b0;
        step(3);
        check("hold_valid", {31'h0, ifc.if_valid}, 32'h1);
        check("hold_pc", ifc.if_pc, 32'h4);

        // Stall in HOLD for three cycles
        ifc.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("stall_req", {31'h0, ifc.imem_req}, 32'h0);
            check("stall_instr", ifc.if_instr, 32'h0109_5020);
            check("stall_pc", ifc.if_pc, 32'h4);
        end
        ifc.stall = 1'b0;
        ifc.imem_ready = 1'b0;
        step(1);
        check("resume_req", {31'h0, ifc.imem_req}, 32'h1);
        check("resume_addr", ifc.imem_addr, 32'h8);
        check("resume_valid", {31'h0, ifc.if_valid}, 32'h0);

        // Branch while the request at 0x8 is outstanding: target 0x0C
        step(1);
        ifc.branch_taken = 1'b1;
        ifc.branch_pc = 32'h10;
        ifc.branch_imm = 16'hFFFE;
        step(1);
        ifc.branch_taken = 1'b0;
        check("squash_addr_held0", ifc.imem_addr, 32'h8);
        step(1);
        check("squash_addr_held1", ifc.imem_addr, 32'h8);
        exp_req.push_back(32'h8);
        ifc.imem_ready = 1'b1;
        step(1);
        check("squash_next_addr", ifc.imem_addr, 32'h0C);
        check("squash_valid", {31'h0, ifc.if_valid}, 32'h0);

        // Branch coincident with ready: target 0x10
        exp_req.push_back(32'h0C);
        ifc.branch_taken = 1'b1;
        ifc.branch_pc = 32'h0;
        ifc.branch_imm = 16'h0003;
        step(1);
        ifc.branch_taken = 1'b0;
        ifc.imem_ready = 1'b0;
        check("coinc_addr", ifc.imem_addr, 32'h10);
        check("coinc_valid", {31'h0, ifc.if_valid}, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        check("coinc_squash_cnt", squash_cnt, 32'd2);
        check("coinc_fetch_cnt", fetch_cnt, 32'd2);
`endif

        // Capture 0x10, then branch in HOLD with stall high: target 0x64
        exp_req.push_back(32'h10);
        exp_ins.push_back('{32'hAC43_0008, 32'h10, OP_SW, 6'h08});
        ifc.imem_ready = 1'b1;
        step(1);
        ifc.imem_ready = 1'b0;
        ifc.stall = 1'b1;
        ifc.branch_taken = 1'b1;
        ifc.branch_pc = 32'h20;
        ifc.branch_imm = 16'h0010;
        step(1);
        ifc.stall = 1'b0;
        ifc.branch_taken = 1'b0;
        check("hold_br_valid", {31'h0, ifc.if_valid}, 32'h0);
        check("hold_br_addr", ifc.imem_addr, 32'h64);
        check("hold_br_req", {31'h0, ifc.imem_req}, 32'h1);

        // Redirect to 0xFFFF_FFFC, fetch there, next request wraps to 0
        exp_req.push_back(32'h64);
        ifc.imem_ready = 1'b1;
        ifc.branch_taken = 1'b1;
        ifc.branch_pc = 32'hFFFF_FFF8;
        ifc.branch_imm = 16'h0000;
        step(1);
        ifc.branch_taken = 1'b0;
        check("wrap_redirect", ifc.imem_addr, 32'hFFFF_FFFC);
        exp_req.push_back(32'hFFFF_FFFC);
        exp_ins.push_back('{32'h1022_0003, 32'hFFFF_FFFC, OP_BEQ, 6'h03});
        step(1);
        ifc.imem_ready = 1'b0;
        check("wrap_if_pc", ifc.if_pc, 32'hFFFF_FFFC);
        step(1);
        check("wrap_addr", ifc.imem_addr, 32'h0);
        check("wrap_req", {31'h0, ifc.imem_req}, 32'h1);
`ifdef FETCH_PERF_CNT_EN
        check("end_squash_cnt", squash_cnt, 32'd3);
        check("end_fetch_cnt", fetch_cnt, 32'd4);
`endif

        // Reset during an outstanding request, RESET_PC = 0x100
        rst1 = 1'b0;
        step(1);
        check("r1_req", {31'h0, ifc1.imem_req}, 32'h1);
        check("r1_addr", ifc1.imem_addr, 32'h100);
        rst1 = 1'b1;
        ifc1.imem_ready = 1'b1;
        step(1);
        check("r1_rst_req", {31'h0, ifc1.imem_req}, 32'h0);
        check("r1_rst_valid", {31'h0, ifc1.if_valid}, 32'h0);
        step(1);
        check("r1_rst_valid2", {31'h0, ifc1.if_valid}, 32'h0);
        rst1 = 1'b0;
        ifc1.imem_ready = 1'b0;
        #1;
        check("r1_rel_req", {31'h0, ifc1.imem_req}, 32'h1);
        check("r1_rel_addr", ifc1.imem_addr, 32'h100);
        step(1);
        check("r1_rel_valid", {31'h0, ifc1.if_valid}, 32'h0);

        step(1);
        check("req_queue_left", exp_req.size(), 32'd0);
        check("ins_queue_left", exp_ins.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: byte address of the first fetch after reset.
REQ-002 clk  in  1: single clock; all state updates on the rising edge.
REQ-003 rst  in  1: reset, synchronous and active-high.
REQ-004 stall  in  1: downstream hold; the held instruction is not consumed this cycle.
REQ-005 branch_taken  in  1: resolved-taken beq from downstream; one-cycle pulse.
REQ-006 branch_pc  in  32: byte PC of the taken branch.
REQ-007 branch_imm  in  16: raw immediate field of the taken branch.
REQ-008 imem_req  out  1: instruction-memory request valid.
REQ-009 imem_addr  out  32: instruction-memory byte address; held stable while imem_req=1 and imem_ready=0.
REQ-010 imem_ready  in  1: memory accepts the request and returns data this cycle.
REQ-011 imem_rdata  in  32: instruction word, valid when imem_ready=1.
REQ-012 if_valid  out  1: if_instr/if_pc hold a live instruction.
REQ-013 if_instr  out  32, if_pc  out  32: fetched word and its byte PC.
REQ-014 opCode  out  6, funct  out  6: if_instr[31:26] and if_instr[5:0] when if_valid=1; 6'h0 otherwise, so the control unit decodes an invalid R-type and enables no writes.

Function
REQ-015 States: FETCH (request outstanding) and HOLD (instruction presented, awaiting consumption).
REQ-016 FETCH: imem_req=1 and imem_addr=req_addr; imem_req is forced to 0 while rst=1.
REQ-017 FETCH, imem_ready=1, squash=0, no branch: if_instr<=imem_rdata, if_pc<=req_addr, if_valid<=1, pc<=req_addr+4, next state HOLD; fetch latency is 1 cycle after ready.
REQ-018 HOLD, stall=0, no branch: the instruction is consumed; if_valid<=0, req_addr<=pc, next state FETCH.
REQ-019 HOLD, stall=1: all outputs and registers are held unchanged.
REQ-020 Branch target = branch_pc + 4 + (sign-extended branch_imm << 2), with 32-bit wrap-around and no overflow flag.
REQ-021 branch_taken in HOLD: if_valid<=0, pc<=target, req_addr<=target, next state FETCH; branch takes priority over stall.
REQ-022 branch_taken in FETCH with imem_ready=0: pc<=target and squash<=1; req_addr is unchanged until the outstanding request completes.
REQ-023 FETCH, imem_ready=1, squash=1: the returned word is discarded, squash<=0, req_addr<=pc, and the state stays FETCH.
REQ-024 branch_taken and imem_ready in the same FETCH cycle: the word is discarded and req_addr<=target; the next request goes to the target.
REQ-025 PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0.

Reset
REQ-026 rst=1 at a clock edge: state<=FETCH, pc<=RESET_PC, req_addr<=RESET_PC, squash<=0, if_valid<=0, if_instr<=0, if_pc<=0, and counters<=0.
REQ-027 Reset mid-request abandons the transaction; any imem_ready seen while rst=1 is ignored.

Configuration
REQ-028 Macro FETCH_PERF_CNT_EN defined: add outputs fetch_cnt[31:0] (increments on each REQ-017 capture) and squash_cnt[31:0] (increments on each discarded word, REQ-023/REQ-024); both saturate at 32'hFFFF_FFFF.
REQ-029 FETCH_PERF_CNT_EN undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Structure
REQ-030 Shared package cpu_pkg holds: the fetch state enum, the RESET_PC default, the opcode constants (R-type 6'h0, addi 6'h8, lw 6'h23, sw 6'h2b, beq 6'h4), and the instruction field bit positions.
REQ-031 Target computation is a combinational sub-module, branch_target_calc (inputs branch_pc and branch_imm; output target).

Verification
REQ-032 Reset release with imem_ready tied 1 and words 0x20080005/0x01095020 at 0x0/0x4 -> imem_addr 0x0 then 0x4; if_valid pulses with opCode 0x08 then 0x00/funct 0x20.
REQ-033 HOLD with stall=1 for 3 cycles -> if_instr and if_pc stable and imem_req=0 throughout; FETCH resumes 1 cycle after stall drops.
REQ-034 imem_ready delayed 4 cycles, branch_taken in cycle 2 (branch_pc=0x10, imm=0xFFFE) -> imem_addr held at the old address until ready, word discarded, next request 0x0C.
REQ-035 branch_taken coincident with imem_ready (branch_pc=0x0, imm=0x0003) -> no if_valid, next imem_addr=0x10, squash_cnt=1 when FETCH_PERF_CNT_EN is defined.
REQ-036 rst asserted during an outstanding request with RESET_PC=0x100 -> imem_req=0 during reset, if_valid=0, first request after release at 0x100.
REQ-037 pc=0xFFFF_FFFC fetch -> next imem_addr=0x0.
